// File: rtl/gpio_ctrl_if.sv
// J1 io bus bundle used by the GPIO peripheral.
// The CPU side drives the strobes, address and write data, and the peripheral returns registered read data.
interface gpio_ctrl_if;
    logic        io_wr;
    logic        io_rd;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;

    modport master (output io_wr, io_rd, io_addr, io_wdata, input io_rdata);
    modport slave  (input io_wr, io_rd, io_addr, io_wdata, output io_rdata);
endinterface

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO peripheral on the J1 io bus.
// Each pin has output and enable registers with atomic set and clear.
// Inputs are synchronised and debounced, then rise and fall edges are captured into W1C status.
// irq is a registered level that is high whenever any status bit is set.

// Per-pin input path: synchroniser, debouncer, edge detector and sticky status bit.
module gpio_pin #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    input  logic rise_en,
    input  logic fall_en,
    input  logic w1c,
    output logic din,
    output logic status
);
    localparam int            CW    = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0] C_MAX = CW'(DB_CNT - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   d_prev;
    logic                   s;
    logic                   edge_hit;

    assign s        = sync[SYNC_STAGES-1];
    assign edge_hit = (rise_en & din & ~d_prev) | (fall_en & ~din & d_prev);

    // Shift the asynchronous pad value through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], pin_in};
    end

    // The debounced value follows s only after DB_CNT consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din <= 1'b0;
            cnt <= '0;
        end else if (s == din) begin
            cnt <= '0;
        end else if (cnt == C_MAX) begin
            din <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Keep the previous debounced value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_prev <= 1'b0;
        else        d_prev <= din;
    end

    // Sticky status bit. A new edge beats a W1C clear in the same cycle so that no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        status <= 1'b0;
        else if (edge_hit) status <= 1'b1;
        else if (w1c)      status <= 1'b0;
    end
endmodule

module gpio_ctrl #(
    parameter int               WIDTH       = 8,
    parameter logic [15:0]      BASE_ADDR   = 16'h0040,
    parameter int               SYNC_STAGES = 2,
    parameter int               DB_CNT      = 4,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_OE   = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_STAT = 3'd3;
    localparam logic [2:0] REG_RISE = 3'd4;
    localparam logic [2:0] REG_FALL = 3'd5;
    localparam logic [2:0] REG_SET  = 3'd6;
    localparam logic [2:0] REG_CLR  = 3'd7;

    logic             hit;
    logic             wr_hit;
    logic             rd_hit;
    logic [2:0]       rsel;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] status;
    logic [15:0]      rd_val;

    // Byte address bit 0 is ignored, so each register occupies one 16-bit word.
    assign hit     = (bus.io_addr[15:4] == BASE_ADDR[15:4]);
    assign rsel    = bus.io_addr[3:1];
    assign wr_hit  = bus.io_wr & hit;
    assign rd_hit  = bus.io_rd & hit;
    assign wdata_w = bus.io_wdata[WIDTH-1:0];
    assign w1c     = (wr_hit && rsel == REG_STAT) ? wdata_w : '0;

    // One input path instance per pin.
    gpio_pin #(
        .SYNC_STAGES(SYNC_STAGES),
        .DB_CNT     (DB_CNT)
    ) u_pin [WIDTH-1:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (gpio_in),
        .rise_en(rise_en),
        .fall_en(fall_en),
        .w1c    (w1c),
        .din    (din),
        .status (status)
    );

    // Writable control registers. SET and CLR give atomic read-modify-write on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= OUT_RESET;
            gpio_oe  <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else if (wr_hit) begin
            case (rsel)
                REG_OUT:  gpio_out <= wdata_w;
                REG_OE:   gpio_oe  <= wdata_w;
                REG_RISE: rise_en  <= wdata_w;
                REG_FALL: fall_en  <= wdata_w;
                REG_SET:  gpio_out <= gpio_out | wdata_w;
                REG_CLR:  gpio_out <= gpio_out & ~wdata_w;
                default:  ;
            endcase
        end
    end

    // Read mux. Unused upper bits and the write-only offsets read back as zero.
    always_comb begin
        rd_val = '0;
        case (rsel)
            REG_OUT:  rd_val[WIDTH-1:0] = gpio_out;
            REG_OE:   rd_val[WIDTH-1:0] = gpio_oe;
            REG_IN:   rd_val[WIDTH-1:0] = din;
            REG_STAT: rd_val[WIDTH-1:0] = status;
            REG_RISE: rd_val[WIDTH-1:0] = rise_en;
            REG_FALL: rd_val[WIDTH-1:0] = fall_en;
            default:  rd_val = '0;
        endcase
    end

    // Registered read data. It samples pre-write state and returns zero when not selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      bus.io_rdata <= '0;
        else if (rd_hit) bus.io_rdata <= rd_val;
        else             bus.io_rdata <= '0;
    end

    // Level interrupt, registered one cycle behind status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= |status;
    end
endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl with WIDTH=8, SYNC_STAGES=2, DB_CNT=4 and OUT_RESET=A5.
module tb_gpio_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gpio_in = '0;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       irq;
    int         checks = 0;
    int         errors = 0;
    logic [15:0] rd;

    gpio_ctrl_if bus();

    gpio_ctrl #(
        .WIDTH      (8),
        .BASE_ADDR  (16'h0040),
        .SYNC_STAGES(2),
        .DB_CNT     (4),
        .OUT_RESET  (8'hA5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus.io_addr = a; bus.io_wdata = d; bus.io_wr = 1'b1;
        tick();
        bus.io_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bus.io_addr = a; bus.io_rd = 1'b1;
        tick();
        bus.io_rd = 1'b0;
        d = bus.io_rdata;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL rst_out got %h exp a5", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL rst_oe got %h exp 00", gpio_oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        checks++; if (bus.io_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h exp 0000", bus.io_rdata); end
        rst_n = 1'b1;
        tick();
        bus_read(16'h0040, rd);
        checks++; if (rd !== 16'h00A5) begin errors++; $display("FAIL rst_read_out got %h exp 00a5", rd); end
    endtask

    task automatic test_set_clr();
        bus_write(16'h0040, 16'h00F0);
        bus_write(16'h004C, 16'h000F);
        bus_write(16'h004E, 16'h0030);
        checks++; if (gpio_out !== 8'hCF) begin errors++; $display("FAIL setclr_out got %h exp cf", gpio_out); end
        bus_read(16'h0050, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL miss_read got %h exp 0000", rd); end
        bus_read(16'h004C, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL set_read got %h exp 0000", rd); end
        bus_write(16'h0042, 16'hFF3C);
        checks++; if (gpio_oe !== 8'h3C) begin errors++; $display("FAIL oe_pin got %h exp 3c", gpio_oe); end
        bus_read(16'h0042, rd);
        checks++; if (rd !== 16'h003C) begin errors++; $display("FAIL oe_read got %h exp 003c", rd); end
        // Simultaneous read and write to DATA_OUT returns the old value.
        bus.io_addr = 16'h0041; bus.io_wdata = 16'h0055; bus.io_wr = 1'b1; bus.io_rd = 1'b1;
        tick();
        bus.io_wr = 1'b0; bus.io_rd = 1'b0;
        checks++; if (bus.io_rdata !== 16'h00CF) begin errors++; $display("FAIL rdwr_read got %h exp 00cf", bus.io_rdata); end
        checks++; if (gpio_out !== 8'h55) begin errors++; $display("FAIL rdwr_out got %h exp 55", gpio_out); end
    endtask

    task automatic test_debounce();
        gpio_in[0] = 1'b1;
        repeat (5) tick();
        bus_read(16'h0044, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL db_early got %h exp 0000", rd); end
        bus_read(16'h0044, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL db_settle got %h exp 0001", rd); end
        gpio_in[0] = 1'b0;
        repeat (10) tick();
        bus_write(16'h0048, 16'h0001);
        gpio_in[0] = 1'b1;
        repeat (3) tick();
        gpio_in[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus_read(16'h0044, rd);
            checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL db_glitch[%0d] got %h exp 0000", i, rd); end
        end
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL db_glitch_stat got %h exp 0000", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL db_glitch_irq got %b exp 0", irq); end
    endtask

    task automatic test_edge_irq();
        gpio_in[0] = 1'b1;
        repeat (6) tick();
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL edge_stat_c7pre got %h exp 0000", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_irq_c7 got %b exp 0", irq); end
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL edge_stat got %h exp 0001", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL edge_irq_c8 got %b exp 1", irq); end
        gpio_in[0] = 1'b0;
        repeat (10) tick();
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL fall_ignored got %h exp 0001", rd); end
        bus_write(16'h0046, 16'h0001);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_lag got %b exp 1", irq); end
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL w1c_stat got %h exp 0000", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
    endtask

    task automatic test_collision();
        gpio_in[0] = 1'b1;
        repeat (6) tick();
        bus_write(16'h0046, 16'h0001);
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL coll_stat got %h exp 0001", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq got %b exp 1", irq); end
        bus_write(16'h0048, 16'h0000);
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL en_clr_keeps got %h exp 0001", rd); end
        bus_write(16'h004A, 16'h0001);
        bus_write(16'h0046, 16'h00FF);
        gpio_in[0] = 1'b0;
        repeat (8) tick();
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL fall_stat got %h exp 0001", rd); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fall_irq got %b exp 1", irq); end
    endtask

    task automatic test_reset_mid();
        gpio_in[0] = 1'b1;
        repeat (3) tick();
        bus_read(16'h004A, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL mid_fall_en got %h exp 0001", rd); end
        rst_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %b exp 0", irq); end
        checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL mid_out got %h exp a5", gpio_out); end
        checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL mid_oe got %h exp 00", gpio_oe); end
        checks++; if (bus.io_rdata !== 16'h0000) begin errors++; $display("FAIL mid_rdata got %h exp 0000", bus.io_rdata); end
        #1;
        rst_n = 1'b1;
        repeat (5) tick();
        bus_read(16'h0044, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_db_early got %h exp 0000", rd); end
        bus_read(16'h0044, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL mid_db_settle got %h exp 0001", rd); end
        repeat (2) tick();
        bus_read(16'h0046, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_stat got %h exp 0000", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq_post got %b exp 0", irq); end
        bus_read(16'h004A, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mid_fall_en_rst got %h exp 0000", rd); end
    endtask

    initial begin
        bus.io_wr = 1'b0; bus.io_rd = 1'b0; bus.io_addr = '0; bus.io_wdata = '0;
        test_reset();
        test_set_clr();
        test_debounce();
        test_edge_irq();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
